// File: rtl/result_drain.sv
// Buffers one MAT_DIM x MAT_DIM result matrix from the final-data stage and
// drains it row-major over valid/ready, tagging each beat with its row/column.
module result_drain #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAT_DIM    = 2,
    localparam int unsigned IDXW      = (MAT_DIM > 1) ? $clog2(MAT_DIM) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_invalid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [IDXW-1:0]       out_row,
    output logic [IDXW-1:0]       out_col,
    output logic                  out_last,
    output logic                  out_elem_invalid,
    output logic                  matrix_invalid,
    output logic                  busy
);

    localparam int unsigned NUM          = MAT_DIM * MAT_DIM;
    localparam int unsigned PW           = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [PW-1:0] LAST_IDX   = PW'(NUM - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN
    } state_t;

    typedef struct packed {
        logic                  invalid;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    state_t        state;
    state_t        state_next;
    entry_t        buffer [NUM];
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] rd_idx;
    logic          mat_inv;
    logic          in_xfer;
    logic          out_xfer;
    logic          draining;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode; ready/valid depend only on state
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = (NUM == 1) ? DRAIN : CAPTURE;
                end
            end
            CAPTURE: begin
                in_ready = 1'b1;
                if (in_valid && (wr_idx == LAST_IDX)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && (rd_idx == LAST_IDX)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // Buffer, pointers and sticky matrix invalid flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx  <= '0;
            rd_idx  <= '0;
            mat_inv <= 1'b0;
            for (int unsigned i = 0; i < NUM; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            if (in_xfer) begin
                buffer[wr_idx] <= '{invalid: in_invalid, data: in_data};
                mat_inv        <= (state == IDLE) ? in_invalid : (mat_inv | in_invalid);
                if (wr_idx == LAST_IDX) begin
                    wr_idx <= '0;
                    rd_idx <= '0;
                end else begin
                    wr_idx <= wr_idx + PW'(1);
                end
            end
            if (out_xfer) begin
                rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + PW'(1);
            end
        end
    end

    // Beat payload is only presented while draining; zero otherwise
    assign draining = (state == DRAIN);

    always_comb begin
        out_data         = '0;
        out_elem_invalid = 1'b0;
        out_row          = '0;
        out_col          = '0;
        out_last         = 1'b0;
        if (draining) begin
            out_data         = buffer[rd_idx].data;
            out_elem_invalid = buffer[rd_idx].invalid;
            out_row          = IDXW'(32'(rd_idx) / MAT_DIM);
            out_col          = IDXW'(32'(rd_idx) % MAT_DIM);
            out_last         = (rd_idx == LAST_IDX);
        end
    end

    assign matrix_invalid = mat_inv;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain (MAT_DIM=2): per-cycle vector table plus
// a hand-written reset-during-drain sequence.
module tb_result_drain;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_invalid;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [0:0] out_row;
    logic [0:0] out_col;
    logic       out_last;
    logic       out_elem_invalid;
    logic       matrix_invalid;
    logic       busy;

    result_drain #(
        .DATA_WIDTH(8),
        .MAT_DIM   (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_invalid      (in_invalid),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_row         (out_row),
        .out_col         (out_col),
        .out_last        (out_last),
        .out_elem_invalid(out_elem_invalid),
        .matrix_invalid  (matrix_invalid),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] id;
        logic       ii;
        logic       ordy;
        logic       ir;
        logic       ov;
        logic [7:0] od;
        logic       row;
        logic       col;
        logic       last;
        logic       ei;
        logic       mi;
        logic       busy;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic rst, input logic iv, input logic [7:0] id,
                                input logic ii, input logic ordy, input logic ir,
                                input logic ov, input logic [7:0] od, input logic row,
                                input logic col, input logic last, input logic ei,
                                input logic mi, input logic bsy);
        vec_t v;
        v.rst = rst; v.iv = iv; v.id = id; v.ii = ii; v.ordy = ordy;
        v.ir = ir; v.ov = ov; v.od = od; v.row = row; v.col = col;
        v.last = last; v.ei = ei; v.mi = mi; v.busy = bsy;
        return v;
    endfunction

    // Expected outputs: reset / idle / capture / drain cycles
    function automatic vec_t rst_row(input logic iv, input logic [7:0] d);
        return mk(1'b1, iv, d, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic vec_t idle(input logic iv, input logic [7:0] d, input logic ii,
                                  input logic ordy, input logic mi);
        return mk(1'b0, iv, d, ii, ordy, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, mi, 1'b0);
    endfunction

    function automatic vec_t cap(input logic iv, input logic [7:0] d, input logic ii,
                                 input logic mi);
        return mk(1'b0, iv, d, ii, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, mi, 1'b1);
    endfunction

    function automatic vec_t drn(input logic iv, input logic [7:0] d, input logic ordy,
                                 input logic [7:0] od, input logic r, input logic c,
                                 input logic l, input logic ei, input logic mi);
        return mk(1'b0, iv, d, 1'b0, ordy, 1'b0, 1'b1, od, r, c, l, ei, mi, 1'b1);
    endfunction

    task automatic chk(input string nm, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (step %0d): got %0h want %0h", nm, step, act, exp);
        end
    endtask

    task automatic check_vec(input int step, input vec_t v);
        chk("in_ready", step, 32'(in_ready), 32'(v.ir));
        chk("out_valid", step, 32'(out_valid), 32'(v.ov));
        chk("out_data", step, 32'(out_data), 32'(v.od));
        chk("out_row", step, 32'(out_row), 32'(v.row));
        chk("out_col", step, 32'(out_col), 32'(v.col));
        chk("out_last", step, 32'(out_last), 32'(v.last));
        chk("out_elem_invalid", step, 32'(out_elem_invalid), 32'(v.ei));
        chk("matrix_invalid", step, 32'(matrix_invalid), 32'(v.mi));
        chk("busy", step, 32'(busy), 32'(v.busy));
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'h55;
        in_invalid = 1'b0;
        out_ready  = 1'b0;

        // Reset held two cycles with a pending input, then no capture
        vecs.push_back(rst_row(1'b1, 8'h55));
        vecs.push_back(rst_row(1'b1, 8'h55));
        vecs.push_back(idle(1'b0, 8'h55, 1'b0, 1'b0, 1'b0));
        // Basic matrix, downstream always ready
        vecs.push_back(idle(1'b1, 8'd10, 1'b0, 1'b0, 1'b0));
        vecs.push_back(cap(1'b1, 8'd20, 1'b0, 1'b0));
        vecs.push_back(cap(1'b1, 8'd30, 1'b0, 1'b0));
        vecs.push_back(cap(1'b1, 8'd40, 1'b0, 1'b0));
        vecs.push_back(drn(1'b0, 8'h00, 1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(drn(1'b0, 8'h00, 1'b1, 8'd20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(drn(1'b0, 8'h00, 1'b1, 8'd30, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(drn(1'b0, 8'h00, 1'b1, 8'd40, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        // Backpressure: out_ready 1,0,0,1,0,1,1
        vecs.push_back(idle(1'b1, 8'd10, 1'b0, 1'b0, 1'b0));
        vecs.push_back(cap(1'b1, 8'd20, 1'b0, 1'b0));
        vecs.push_back(cap(1'b1, 8'd30, 1'b0, 1'b0));
        vecs.push_back(cap(1'b1, 8'd40, 1'b0, 1'b0));
        vecs.push_back(drn(1'b0, 8'h00, 1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(drn(1'b0, 8'h00, 1'b0, 8'd20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(drn(1'b0, 8'h00, 1'b0, 8'd20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(drn(1'b0, 8'h00, 1'b1, 8'd20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(drn(1'b0, 8'h00, 1'b0, 8'd30, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(drn(1'b0, 8'h00, 1'b1, 8'd30, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(drn(1'b0, 8'h00, 1'b1, 8'd40, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(idle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0));
        vecs.push_back(idle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0));
        // Element 2 overflowed, then a clean matrix clears the sticky flag
        vecs.push_back(idle(1'b1, 8'h01, 1'b0, 1'b0, 1'b0));
        vecs.push_back(cap(1'b1, 8'h02, 1'b0, 1'b0));
        vecs.push_back(cap(1'b1, 8'hFF, 1'b1, 1'b0));
        vecs.push_back(cap(1'b1, 8'h04, 1'b0, 1'b1));
        vecs.push_back(drn(1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(drn(1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        vecs.push_back(drn(1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
        vecs.push_back(drn(1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1));
        vecs.push_back(idle(1'b1, 8'h05, 1'b0, 1'b0, 1'b1));
        vecs.push_back(cap(1'b1, 8'h06, 1'b0, 1'b0));
        vecs.push_back(cap(1'b1, 8'h07, 1'b0, 1'b0));
        vecs.push_back(cap(1'b1, 8'h08, 1'b0, 1'b0));
        vecs.push_back(drn(1'b0, 8'h00, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(drn(1'b0, 8'h00, 1'b1, 8'h06, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(drn(1'b0, 8'h00, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(drn(1'b0, 8'h00, 1'b1, 8'h08, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        // Upstream gaps, then in_valid held during drain must be ignored
        vecs.push_back(idle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0));
        vecs.push_back(cap(1'b0, 8'hEE, 1'b0, 1'b0));
        vecs.push_back(cap(1'b1, 8'h22, 1'b0, 1'b0));
        vecs.push_back(cap(1'b0, 8'hEE, 1'b0, 1'b0));
        vecs.push_back(cap(1'b1, 8'h33, 1'b0, 1'b0));
        vecs.push_back(cap(1'b1, 8'h44, 1'b0, 1'b0));
        vecs.push_back(drn(1'b1, 8'hAA, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(drn(1'b1, 8'hAA, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(drn(1'b1, 8'hAA, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(drn(1'b1, 8'hAA, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(idle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0));

        foreach (vecs[i]) begin
            @(negedge clk);
            reset      = vecs[i].rst;
            in_valid   = vecs[i].iv;
            in_data    = vecs[i].id;
            in_invalid = vecs[i].ii;
            out_ready  = vecs[i].ordy;
            #1;
            check_vec(i, vecs[i]);
        end

        // Reset after the second output transfer abandons the matrix
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'(8'h61 + k);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_seq valid0", 100, 32'(out_valid), 32'd1);
        chk("rst_seq data0", 100, 32'(out_data), 32'h61);
        @(negedge clk);
        #1;
        chk("rst_seq data1", 101, 32'(out_data), 32'h62);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_seq data2", 102, 32'(out_data), 32'h63);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_seq valid_after_rst", 103, 32'(out_valid), 32'd0);
        chk("rst_seq busy_after_rst", 103, 32'(busy), 32'd0);
        chk("rst_seq ready_after_rst", 103, 32'(in_ready), 32'd1);
        @(negedge clk);
        #1;
        chk("rst_seq stays_idle", 104, 32'(out_valid), 32'd0);

        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'(k + 1);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk("new valid", 110 + k, 32'(out_valid), 32'd1);
            chk("new data", 110 + k, 32'(out_data), 32'(k + 1));
            chk("new row", 110 + k, 32'(out_row), 32'(k / 2));
            chk("new col", 110 + k, 32'(out_col), 32'(k % 2));
            chk("new last", 110 + k, 32'(out_last), 32'(k == 3));
        end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("new done valid", 120, 32'(out_valid), 32'd0);
        chk("new done ready", 120, 32'(in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
